// File: rtl/pipe_pkg.sv
// Shared pipeline types: the decoded control bundle carried from ID into EX
// and the write-back source encodings.
package pipe_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int PCNT_W_DEF = 16;

    typedef struct packed {
        logic       ALUASrc;
        logic       ALUBSrc;
        logic [3:0] ALUOp;
        logic [4:0] BrOp;
        logic       DMWr;
        logic [2:0] DMCtrl;
        logic       RUWr;
        logic [1:0] RUDataWrSrc;
    } ctrl_t;

    localparam ctrl_t      CTRL_NOP   = '0;
    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use detector: a load sitting in EX whose destination is read by the
// instruction currently in ID cannot be satisfied by any bypass in time.
module id_ex_hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              i_id_valid,
    input  logic              i_ex_valid,
    input  ctrl_t             i_ex_ctrl,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_uses_rs1,
    input  logic              i_id_uses_rs2,
    output logic              o_load_use
);

    logic w_ex_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_ex_is_load = i_ex_valid && (i_ex_ctrl.RUDataWrSrc == WB_SRC_MEM)
                          && (i_ex_rd != '0);
    assign w_rs1_hit    = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit    = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_load_use   = i_id_valid && w_ex_is_load && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, same-cycle WB
// bypass into the captured operands and a saturating bubble counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int PCNT_W = PCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_ru1,
    input  logic [XLEN-1:0]   id_ru2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  ctrl_t             id_ctrl,
    input  logic              wb_ruwr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_flush,
    input  logic              hold,
    output logic              stall_o,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_ru1,
    output logic [XLEN-1:0]   ex_ru2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output ctrl_t             ex_ctrl,
    output logic [PCNT_W-1:0] bubble_cnt
);

    logic              r_ex_valid;
    logic [XLEN-1:0]   r_ex_pc;
    logic [XLEN-1:0]   r_ex_ru1;
    logic [XLEN-1:0]   r_ex_ru2;
    logic [XLEN-1:0]   r_ex_imm;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic [REG_AW-1:0] r_ex_rd;
    ctrl_t             r_ex_ctrl;
    logic [PCNT_W-1:0] r_bubble_cnt;

    logic w_load_use;
    logic w_wb_live;
    logic w_byp_rs1;
    logic w_byp_rs2;
    logic w_ref_rs1;
    logic w_ref_rs2;

    id_ex_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .i_id_valid    (id_valid),
        .i_ex_valid    (r_ex_valid),
        .i_ex_ctrl     (r_ex_ctrl),
        .i_ex_rd       (r_ex_rd),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .o_load_use    (w_load_use)
    );

    // Bypass compares against ID sources on capture, against held EX sources on refresh
    assign w_wb_live = wb_ruwr && (wb_rd != '0);
    assign w_byp_rs1 = w_wb_live && (wb_rd == id_rs1);
    assign w_byp_rs2 = w_wb_live && (wb_rd == id_rs2);
    assign w_ref_rs1 = w_wb_live && (wb_rd == r_ex_rs1);
    assign w_ref_rs2 = w_wb_live && (wb_rd == r_ex_rs2);

    assign stall_o = rst_n && !ex_flush && (hold || w_load_use);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_pc      <= '0;
            r_ex_ru1     <= '0;
            r_ex_ru2     <= '0;
            r_ex_imm     <= '0;
            r_ex_rs1     <= '0;
            r_ex_rs2     <= '0;
            r_ex_rd      <= '0;
            r_ex_ctrl    <= CTRL_NOP;
            r_bubble_cnt <= '0;
        end else if (ex_flush || (!hold && w_load_use)) begin
            // Flush and bubble clear EX identically; only a bubble is counted
            r_ex_valid <= 1'b0;
            r_ex_pc    <= '0;
            r_ex_ru1   <= '0;
            r_ex_ru2   <= '0;
            r_ex_imm   <= '0;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
            r_ex_rd    <= '0;
            r_ex_ctrl  <= CTRL_NOP;
            if (!ex_flush && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + PCNT_W'(1);
            end
        end else if (hold) begin
            if (w_ref_rs1) begin
                r_ex_ru1 <= wb_data;
            end
            if (w_ref_rs2) begin
                r_ex_ru2 <= wb_data;
            end
        end else begin
            r_ex_valid <= id_valid;
            r_ex_pc    <= id_pc;
            r_ex_ru1   <= w_byp_rs1 ? wb_data : id_ru1;
            r_ex_ru2   <= w_byp_rs2 ? wb_data : id_ru2;
            r_ex_imm   <= id_imm;
            r_ex_rs1   <= id_rs1;
            r_ex_rs2   <= id_rs2;
            r_ex_rd    <= id_rd;
            r_ex_ctrl  <= id_ctrl;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_pc      = r_ex_pc;
    assign ex_ru1     = r_ex_ru1;
    assign ex_ru2     = r_ex_ru2;
    assign ex_imm     = r_ex_imm;
    assign ex_rs1     = r_ex_rs1;
    assign ex_rs2     = r_ex_rs2;
    assign ex_rd      = r_ex_rd;
    assign ex_ctrl    = r_ex_ctrl;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table-driven capture/bypass vectors plus
// hand-written load-use, flush, hold-refresh and saturation sequences.
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_ru1, id_ru2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    ctrl_t       id_ctrl;
    logic        wb_ruwr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_flush, hold;

    logic        stall_o, ex_valid;
    logic [31:0] ex_pc, ex_ru1, ex_ru2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    ctrl_t       ex_ctrl;
    logic [15:0] bubble_cnt;

    logic        stallS, exValidS;
    logic [31:0] exPcS, exRu1S, exRu2S, exImmS;
    logic [4:0]  exRs1S, exRs2S, exRdS;
    ctrl_t       exCtrlS;
    logic [1:0]  bubbleCntS;

    int nCompared   = 0;
    int nMismatched = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_ru1(id_ru1), .id_ru2(id_ru2), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_ctrl(id_ctrl), .wb_ruwr(wb_ruwr),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush), .hold(hold),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ru1(ex_ru1),
        .ex_ru2(ex_ru2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter copy on the same stimulus makes saturation reachable quickly
    id_ex_stage #(.PCNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_ru1(id_ru1), .id_ru2(id_ru2), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_ctrl(id_ctrl), .wb_ruwr(wb_ruwr),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush), .hold(hold),
        .stall_o(stallS), .ex_valid(exValidS), .ex_pc(exPcS), .ex_ru1(exRu1S),
        .ex_ru2(exRu2S), .ex_imm(exImmS), .ex_rs1(exRs1S), .ex_rs2(exRs2S),
        .ex_rd(exRdS), .ex_ctrl(exCtrlS), .bubble_cnt(bubbleCntS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc, ru1, ru2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        wbWr;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
        logic        expValid;
        logic [31:0] expPc, expRu1, expRu2;
        logic [4:0]  expRd;
    } vec_t;

    vec_t  vecs [7];
    ctrl_t ctrlAlu;
    ctrl_t ctrlLoad;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        id_valid    = v.valid;
        id_pc       = v.pc;
        id_ru1      = v.ru1;
        id_ru2      = v.ru2;
        id_imm      = v.imm;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_rd       = v.rd;
        id_uses_rs1 = 1'b1;
        id_uses_rs2 = 1'b1;
        id_ctrl     = ctrlAlu;
        wb_ruwr     = v.wbWr;
        wb_rd       = v.wbRd;
        wb_data     = v.wbData;
    endtask

    task automatic setInstr(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rd, input ctrl_t c);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_ru1      = 32'h0;
        id_ru2      = 32'h0;
        id_imm      = 32'h0;
        id_rs1      = rs1;
        id_rs2      = 5'd0;
        id_rd       = rd;
        id_uses_rs1 = u1;
        id_uses_rs2 = 1'b0;
        id_ctrl     = c;
        wb_ruwr     = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'h0;
    endtask

    initial begin
        ctrlAlu  = CTRL_NOP;
        ctrlAlu.ALUOp = 4'h2;
        ctrlAlu.RUWr  = 1'b1;
        ctrlAlu.RUDataWrSrc = WB_SRC_ALU;
        ctrlLoad = CTRL_NOP;
        ctrlLoad.ALUBSrc = 1'b1;
        ctrlLoad.DMCtrl  = 3'b010;
        ctrlLoad.RUWr    = 1'b1;
        ctrlLoad.RUDataWrSrc = WB_SRC_MEM;

        //             valid pc      ru1     ru2     imm    rs1 rs2 rd  wbWr wbRd wbData    expV expPc   expRu1   expRu2   expRd
        vecs[0] = '{1'b1, 32'h40, 32'h5,  32'h0,  32'h0, 1,  2,  3,  1'b0, 0,  32'h0,    1'b1, 32'h40, 32'h5,   32'h0,   3};
        vecs[1] = '{1'b1, 32'h44, 32'h1,  32'h0,  32'h4, 1,  7,  4,  1'b1, 7,  32'hDEAD, 1'b1, 32'h44, 32'h1,   32'hDEAD, 4};
        vecs[2] = '{1'b1, 32'h48, 32'h1,  32'h0,  32'h4, 1,  0,  4,  1'b1, 0,  32'hDEAD, 1'b1, 32'h48, 32'h1,   32'h0,   4};
        vecs[3] = '{1'b1, 32'h4C, 32'h1,  32'h11, 32'h4, 1,  7,  4,  1'b0, 7,  32'hDEAD, 1'b1, 32'h4C, 32'h1,   32'h11,  4};
        vecs[4] = '{1'b1, 32'h50, 32'h2,  32'h22, 32'h0, 12, 13, 8,  1'b1, 12, 32'h1234, 1'b1, 32'h50, 32'h1234, 32'h22, 8};
        vecs[5] = '{1'b1, 32'h54, 32'h2,  32'h22, 32'h0, 3,  3,  9,  1'b1, 3,  32'hBEEF, 1'b1, 32'h54, 32'hBEEF, 32'hBEEF, 9};
        vecs[6] = '{1'b0, 32'h58, 32'h6,  32'h7,  32'h0, 1,  2,  10, 1'b0, 0,  32'h0,    1'b0, 32'h58, 32'h6,   32'h7,   10};

        // Reset with ID valid and hold asserted: stall must stay low
        rst_n = 1'b0; ex_flush = 1'b0; hold = 1'b1;
        setInstr(32'h10, 5'd1, 1'b1, 5'd2, ctrlLoad);
        step(); step();
        checkOutput("reset_stall", 32'(stall_o), 32'h0);
        checkOutput("reset_valid", 32'(ex_valid), 32'h0);
        checkOutput("reset_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("reset_pc", ex_pc, 32'h0);
        checkOutput("reset_cnt", 32'(bubble_cnt), 32'h0);
        checkOutput("reset_cnt_sat", 32'(bubbleCntS), 32'h0);
        hold = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_pc", i), ex_pc, vecs[i].expPc);
            checkOutput($sformatf("vec%0d_ru1", i), ex_ru1, vecs[i].expRu1);
            checkOutput($sformatf("vec%0d_ru2", i), ex_ru2, vecs[i].expRu2);
            checkOutput($sformatf("vec%0d_rd", i), 32'(ex_rd), 32'(vecs[i].expRd));
        end
        checkOutput("vec_ctrl", 32'(ex_ctrl), 32'(ctrlAlu));

        // Load-use: load rd=5 in EX, add reading x5 in ID
        setInstr(32'h100, 5'd0, 1'b0, 5'd5, ctrlLoad);
        step();
        checkOutput("lu_load_rd", 32'(ex_rd), 32'd5);
        setInstr(32'h104, 5'd5, 1'b1, 5'd6, ctrlAlu);
        #1;
        checkOutput("lu_stall", 32'(stall_o), 32'h1);
        step();
        checkOutput("lu_bubble_valid", 32'(ex_valid), 32'h0);
        checkOutput("lu_bubble_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("lu_cnt", 32'(bubble_cnt), 32'h1);
        checkOutput("lu_stall_drop", 32'(stall_o), 32'h0);
        step();
        checkOutput("lu_add_valid", 32'(ex_valid), 32'h1);
        checkOutput("lu_add_pc", ex_pc, 32'h104);
        checkOutput("lu_cnt_once", 32'(bubble_cnt), 32'h1);

        // Flush overrides both a pending load-use and hold
        setInstr(32'h110, 5'd0, 1'b0, 5'd5, ctrlLoad);
        step();
        setInstr(32'h114, 5'd5, 1'b1, 5'd6, ctrlAlu);
        hold = 1'b1; ex_flush = 1'b1;
        #1;
        checkOutput("flush_stall", 32'(stall_o), 32'h0);
        step();
        checkOutput("flush_valid", 32'(ex_valid), 32'h0);
        checkOutput("flush_pc", ex_pc, 32'h0);
        checkOutput("flush_cnt", 32'(bubble_cnt), 32'h1);
        hold = 1'b0; ex_flush = 1'b0;

        // Hold with WB writing EX's rs1: only ex_ru1 refreshes
        setInstr(32'h200, 5'd4, 1'b1, 5'd9, ctrlAlu);
        id_ru1 = 32'h1; id_rs2 = 5'd8; id_ru2 = 32'h2; id_imm = 32'h33;
        step();
        setInstr(32'h300, 5'd1, 1'b1, 5'd1, ctrlLoad);
        hold = 1'b1; wb_ruwr = 1'b1; wb_rd = 5'd4; wb_data = 32'h9;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("hold%0d_stall", i), 32'(stall_o), 32'h1);
        end
        checkOutput("hold_ru1", ex_ru1, 32'h9);
        checkOutput("hold_ru2", ex_ru2, 32'h2);
        checkOutput("hold_pc", ex_pc, 32'h200);
        checkOutput("hold_imm", ex_imm, 32'h33);
        checkOutput("hold_valid", 32'(ex_valid), 32'h1);
        checkOutput("hold_cnt", 32'(bubble_cnt), 32'h1);
        hold = 1'b0;

        // Five more load-use bubbles: wide counter reaches 6, 2-bit copy pins at 3
        for (int i = 0; i < 5; i++) begin
            setInstr(32'h400 + 32'(i * 8), 5'd0, 1'b0, 5'd5, ctrlLoad);
            step();
            setInstr(32'h404 + 32'(i * 8), 5'd5, 1'b1, 5'd6, ctrlAlu);
            step();
            step();
        end
        checkOutput("sat_cnt_wide", 32'(bubble_cnt), 32'd6);
        checkOutput("sat_cnt_narrow", 32'(bubbleCntS), 32'd3);
        checkOutput("sat_last_pc", ex_pc, 32'h424);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
